// File: rtl/osmanip_hps_pkg.sv
// Shared types and default widths for the HPS on-chip RAM burst reader.
package osmanip_hps_pkg;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } hps_state_e;

    // Occupancy counter width for a power-of-two FIFO (holds 0..depth).
    function automatic int unsigned fifo_cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/osmanip_hps_sync_fifo.sv
// Synchronous show-ahead FIFO: head word is presented whenever valid_o is high.
module osmanip_hps_sync_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              valid_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    assign push_ok = push_i && (count_q != CNT_W'(DEPTH));
    assign pop_ok  = pop_i && (count_q != '0);

    // Simultaneous push and pop leave the occupancy unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign valid_o   = (count_q != '0);
    assign count_o   = count_q;

endmodule

// File: rtl/osmanip_hps_ram_reader.sv
// Reads a burst of words from an on-chip RAM (fixed 1-cycle latency) and streams them out.
module osmanip_hps_ram_reader #(
    parameter int unsigned ADDR_W     = osmanip_hps_pkg::ADDR_W,
    parameter int unsigned DATA_W     = osmanip_hps_pkg::DATA_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     length,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   address,
    output logic                chipselect,
    output logic                write,
    output logic [DATA_W/8-1:0] byteenable,
    output logic                clken,
    input  logic [DATA_W-1:0]   readdata,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last
);

    import osmanip_hps_pkg::*;

    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned CNT_W = fifo_cnt_w(FIFO_DEPTH);
    localparam int unsigned OCC_W = CNT_W + 1;

    hps_state_e        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  issued_q, issued_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic              chipselect_q, chipselect_d;
    logic              rd_valid_q;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              fifo_valid;
    logic [CNT_W-1:0]  fifo_count;
    logic [OCC_W-1:0]  committed;
    logic              credit_ok;
    logic              pop;
    logic              is_last_beat;

    // Words already buffered plus reads still travelling through the RAM pipeline.
    assign committed = OCC_W'(fifo_count) + OCC_W'(chipselect_q) + OCC_W'(rd_valid_q);
    assign credit_ok = committed < OCC_W'(FIFO_DEPTH);

    assign pop          = fifo_valid && out_ready;
    assign is_last_beat = (beat_q == (len_q - LEN_W'(1)));

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        len_d        = len_q;
        issued_d     = issued_q;
        beat_d       = beat_q;
        address_d    = address_q;
        chipselect_d = 1'b0;

        if (pop) begin
            beat_d = beat_q + LEN_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d = base_addr;
                    len_d  = length;
                    beat_d = '0;
                    if (length == '0) begin
                        issued_d = '0;
                        state_d  = DONE;
                    end else begin
                        // First read goes out with the ISSUE state; the FIFO is empty here.
                        chipselect_d = 1'b1;
                        address_d    = base_addr;
                        issued_d     = LEN_W'(1);
                        state_d      = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (issued_q == len_q) begin
                    state_d = DRAIN;
                end else if (credit_ok) begin
                    chipselect_d = 1'b1;
                    address_d    = base_q + issued_q[ADDR_W-1:0];
                    issued_d     = issued_q + LEN_W'(1);
                    if ((issued_q + LEN_W'(1)) == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && is_last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            base_q       <= '0;
            len_q        <= '0;
            issued_q     <= '0;
            beat_q       <= '0;
            address_q    <= '0;
            chipselect_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            len_q        <= len_d;
            issued_q     <= issued_d;
            beat_q       <= beat_d;
            address_q    <= address_d;
            chipselect_q <= chipselect_d;
            rd_valid_q   <= chipselect_q;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    osmanip_hps_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (rd_valid_q),
        .push_data_i (readdata),
        .pop_i       (pop),
        .rd_data_o   (out_data),
        .valid_o     (fifo_valid),
        .count_o     (fifo_count)
    );

    assign busy       = busy_q;
    assign done       = done_q;
    assign address    = address_q;
    assign chipselect = chipselect_q;
    assign write      = 1'b0;
    assign byteenable = '1;
    assign clken      = 1'b1;
    assign out_valid  = fifo_valid;
    assign out_last   = fifo_valid && is_last_beat;

endmodule

// File: tb/tb_osmanip_hps_ram_reader.sv
// Directed bench for osmanip_hps_ram_reader with a 1-cycle-latency RAM model.
module tb_osmanip_hps_ram_reader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic        busy;
    logic        done;
    logic [9:0]  address;
    logic        chipselect;
    logic        write;
    logic [3:0]  byteenable;
    logic        clken;
    logic [31:0] readdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    osmanip_hps_ram_reader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .address    (address),
        .chipselect (chipselect),
        .write      (write),
        .byteenable (byteenable),
        .clken      (clken),
        .readdata   (readdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM preloaded with addr + 0x100, one cycle read latency.
    logic [31:0] ram [1024];
    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'(i) + 32'h100;
        readdata = '0;
    end
    always @(posedge clk) begin
        if (chipselect) readdata <= ram[address];
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: cycle numbers count edges after the start-accepting edge (0 = first cycle after it).
    logic        mon_clr;
    logic [31:0] beat_data [$];
    bit          beat_last [$];
    int          beat_cyc  [$];
    logic [9:0]  addr_log  [$];
    int          cyc, cs_total, beat_total, busy_cnt, done_cnt, first_done, stall_err, max_out;
    logic [31:0] held;
    bit          stalled;

    initial begin
        cyc = 0; cs_total = 0; beat_total = 0; busy_cnt = 0; done_cnt = 0;
        first_done = -100; stall_err = 0; max_out = 0; held = '0; stalled = 0;
        forever begin
            @(negedge clk);
            if (mon_clr) begin
                beat_data.delete(); beat_last.delete(); beat_cyc.delete(); addr_log.delete();
                cyc = -1; cs_total = 0; beat_total = 0; busy_cnt = 0; done_cnt = 0;
                first_done = -100; stall_err = 0; max_out = 0; stalled = 0;
            end else begin
                cyc++;
                if (chipselect) begin
                    addr_log.push_back(address);
                    cs_total++;
                end
                if (busy) busy_cnt++;
                if (done) begin
                    if (done_cnt == 0) first_done = cyc;
                    done_cnt++;
                end
                if (cs_total - beat_total > max_out) max_out = cs_total - beat_total;
                if (stalled && (!out_valid || out_data !== held)) stall_err++;
                if (out_valid && out_ready) begin
                    beat_data.push_back(out_data);
                    beat_last.push_back(out_last);
                    beat_cyc.push_back(cyc);
                    beat_total++;
                end
                stalled = out_valid && !out_ready;
                held    = out_data;
            end
        end
    end

    // Start a burst and wait (bounded) for done; ready low for low_cycles, or toggling 1010...
    task automatic run_burst(input logic [9:0] b, input logic [10:0] l,
                             input int low_cycles, input bit toggle);
        bit seen;
        seen      = 0;
        mon_clr   = 1'b1;
        start     = 1'b1;
        base_addr = b;
        length    = l;
        out_ready = 1'b1;
        tick();
        mon_clr = 1'b0;
        start   = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (toggle) out_ready = (i % 2 == 0);
            else        out_ready = (i >= low_cycles);
            tick();
            if (done_cnt != 0) seen = 1;
        end
        out_ready = 1'b1;
        tick();
        tick();
        check("done_seen", 32'(seen), 32'd1);
    endtask

    // Beats in order with data = ((b + k) mod 1024) + 0x100 and out_last only on the final one.
    task automatic check_stream(input string tag, input logic [9:0] b, input int n);
        int lasts;
        lasts = 0;
        check({tag, "_n_beats"}, 32'(beat_data.size()), 32'(n));
        for (int k = 0; k < n; k++) begin
            logic [9:0] a;
            a = b + 10'(k);
            check($sformatf("%s_data%0d", tag, k), beat_data[k], 32'(a) + 32'h100);
        end
        foreach (beat_last[k]) if (beat_last[k]) lasts++;
        check({tag, "_last_cnt"}, 32'(lasts), 32'd1);
        check({tag, "_last_pos"}, 32'(beat_last[n-1]), 32'd1);
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1; mon_clr = 1'b1;
        repeat (3) tick();
        check("rst_cs",    32'(chipselect), 32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_done",  32'(done),       32'd0);
        check("rst_valid", 32'(out_valid),  32'd0);
        check("rst_last",  32'(out_last),   32'd0);
        check("rst_addr",  32'(address),    32'd0);
        check("write",     32'(write),      32'd0);
        check("be",        32'(byteenable), 32'hF);
        check("clken",     32'(clken),      32'd1);
        reset   = 1'b0;
        mon_clr = 1'b0;
        tick();

        // base 5, len 3, ready held high
        run_burst(10'd5, 11'd3, 0, 1'b0);
        check_stream("b5", 10'd5, 3);
        check("b5_cyc0", 32'(beat_cyc[0]), 32'd2);
        check("b5_cyc2", 32'(beat_cyc[2]), 32'd4);
        check("b5_done_cyc", 32'(first_done), 32'd5);
        check("b5_busy_cnt", 32'(busy_cnt), 32'd6);
        check("b5_addr0", 32'(addr_log[0]), 32'd5);
        check("b5_addr2", 32'(addr_log[2]), 32'd7);
        check("b5_cs_cnt", 32'(cs_total), 32'd3);

        // zero length
        run_burst(10'd9, 11'd0, 0, 1'b0);
        check("z_cs_cnt",   32'(cs_total),   32'd0);
        check("z_done_cyc", 32'(first_done), 32'd0);
        check("z_done_cnt", 32'(done_cnt),   32'd1);
        check("z_busy_cnt", 32'(busy_cnt),   32'd1);
        check("z_beats",    32'(beat_data.size()), 32'd0);

        // address wrap
        run_burst(10'd1022, 11'd4, 0, 1'b0);
        check_stream("wrap", 10'd1022, 4);
        check("wrap_addr0", 32'(addr_log[0]), 32'd1022);
        check("wrap_addr1", 32'(addr_log[1]), 32'd1023);
        check("wrap_addr2", 32'(addr_log[2]), 32'd0);
        check("wrap_addr3", 32'(addr_log[3]), 32'd1);
        check("wrap_d2",    beat_data[2],     32'h100);

        // long stall: outstanding reads capped at FIFO depth
        run_burst(10'd100, 11'd16, 10, 1'b0);
        check_stream("stall", 10'd100, 16);
        check("stall_max_out", 32'(max_out), 32'd4);
        check("stall_cs_cnt",  32'(cs_total), 32'd16);
        check("stall_hold",    32'(stall_err), 32'd0);

        // toggling ready
        run_burst(10'd300, 11'd8, 0, 1'b1);
        check_stream("tog", 10'd300, 8);
        check("tog_hold", 32'(stall_err), 32'd0);

        // reset on the 3rd beat of a len=10 burst
        mon_clr = 1'b1; start = 1'b1; base_addr = 10'd20; length = 11'd10; out_ready = 1'b1;
        tick();
        mon_clr = 1'b0; start = 1'b0;
        repeat (4) tick();
        check("abt_valid_pre", 32'(out_valid), 32'd1);
        check("abt_data_pre",  out_data,       32'h116);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abt_cs",    32'(chipselect), 32'd0);
        check("abt_valid", 32'(out_valid),  32'd0);
        check("abt_busy",  32'(busy),       32'd0);
        check("abt_addr",  32'(address),    32'd0);
        repeat (4) tick();
        check("abt_valid_late", 32'(out_valid), 32'd0);
        check("abt_cs_late",    32'(chipselect), 32'd0);
        check("abt_no_done",    32'(done_cnt),  32'd0);

        run_burst(10'd7, 11'd2, 0, 1'b0);
        check_stream("post", 10'd7, 2);
        check("post_cyc0", 32'(beat_cyc[0]), 32'd2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/osmanip_hps_ram_reader.md
OSMANIP_HPS_RAM_READER -- requirements
Module: osmanip_hps_ram_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, the word-address width of the on-chip RAM.
REQ-002 SHALL have parameter DATA_W, default 32, the RAM and stream data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4 (power of two, ≥2), the output buffer depth in words.
REQ-004 SHALL have port clk  in  1  single clock; all logic is rising-edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle request; sampled only in IDLE.
REQ-007 SHALL have port base_addr  in  ADDR_W  first word address of the burst.
REQ-008 SHALL have port length  in  ADDR_W+1  number of words to read (0..1024).
REQ-009 SHALL have port busy  out  1  high from the accepted start until done.
REQ-010 SHALL have port done  out  1  one-cycle pulse after the last word leaves the stream.
REQ-011 SHALL have port address  out  ADDR_W  RAM word address.
REQ-012 SHALL have port chipselect  out  1  RAM select.
REQ-013 SHALL have port write  out  1  tied to 0.
REQ-014 SHALL have port byteenable  out  DATA_W/8  tied to all ones.
REQ-015 SHALL have port clken  out  1  tied to 1.
REQ-016 SHALL have port readdata  in  DATA_W  RAM read data, valid one cycle after a read is issued.
REQ-017 SHALL have port out_data  out  DATA_W  stream data.
REQ-018 SHALL have port out_valid  out  1  stream valid.
REQ-019 SHALL have port out_ready  in  1  stream ready; a beat transfers when out_valid and out_ready are both high.
REQ-020 SHALL have port out_last  out  1  high on the final beat of a burst.

Function
REQ-021 SHALL implement FSM states IDLE, ISSUE, DRAIN and DONE.
REQ-022 IDLE→ISSUE SHALL occur when start=1 and length≠0; the block latches base_addr and length.
REQ-023 IDLE→DONE SHALL occur when start=1 and length=0; no read is issued and done pulses the next cycle.
REQ-024 A read SHALL issue in ISSUE (chipselect=1, address=base+issued count) only when the FIFO free count minus in-flight reads is ≥1; otherwise chipselect=0.
REQ-025 Read latency SHALL be fixed at 1: readdata is pushed into the FIFO on the cycle after the issue, with no other qualification.
REQ-026 address SHALL wrap modulo 2^ADDR_W; e.g. base 1022, length 4 reads 1022, 1023, 0, 1.
REQ-027 ISSUE→DRAIN SHALL occur after the length-th read issues; DRAIN→DONE SHALL occur when the final beat transfers.
REQ-028 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-029 out_last SHALL be high only with the beat whose index is length-1.
REQ-030 Stream data SHALL hold steady while out_valid=1 and out_ready=0.
REQ-031 A push and a pop in the same cycle SHALL both be honoured and leave the occupancy unchanged.
REQ-032 The FIFO SHALL never overflow under any out_ready pattern.
REQ-033 start outside IDLE SHALL be ignored.
REQ-034 Throughput SHALL be one word per clock when out_ready is held high.
REQ-035 Latency from start to the first out_valid SHALL be 2 cycles.

Reset
REQ-036 On reset: FSM=IDLE; chipselect, busy, done, out_valid and out_last=0; address=0; FIFO empty; counters=0.
REQ-037 Reset mid-burst SHALL abort the burst on the next edge; no further reads are issued, the in-flight read is discarded, and done is not pulsed.

Structure
REQ-038 A shared package osmanip_hps_pkg SHALL hold the FSM state enum and the constants ADDR_W=10 and DATA_W=32.
REQ-039 The FIFO SHALL be one sub-module, osmanip_hps_sync_fifo (synchronous, show-ahead, with count output).

Verification
REQ-040 The bench SHALL cover: RAM preloaded with addr+0x100, start base=5 len=3, out_ready=1 → beats 0x105, 0x106, 0x107 on cycles 2-4, out_last on 0x107, done one cycle later.
REQ-041 The bench SHALL cover: len=0 → no chipselect, done pulses 1 cycle after start, busy high for 1 cycle.
REQ-042 The bench SHALL cover: base=1022 len=4 → addresses 1022, 1023, 0, 1 with data in order.
REQ-043 The bench SHALL cover: len=16 with out_ready low for 10 cycles → at most FIFO_DEPTH reads outstanding plus buffered, no data lost or reordered.
REQ-044 The bench SHALL cover: out_ready toggling 1010… with len=8 → all 8 words in order and data held stable during stalls.
REQ-045 The bench SHALL cover: reset asserted on the 3rd beat of a len=10 burst → chipselect=0 and out_valid=0 the next cycle, no done, and a new start then works normally.
